// File: rtl/mmc_pkg.sv
// Shared constants and types for the videocard launch master:
// register map, launch status codes and the launch FSM states.
package mmc_pkg;

    typedef logic [2:0] addr_t;

    localparam addr_t ADDR_START    = 3'd0;
    localparam addr_t ADDR_IRQ      = 3'd1;
    localparam addr_t ADDR_CORE_EN0 = 3'd2;

    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_TIMEOUT  = 2'b01,
        ST_BAD_MASK = 2'b10
    } status_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_EN,
        S_WR_START,
        S_HOLD,
        S_POLL_RD,
        S_POLL_WAIT,
        S_GAP,
        S_CLEAR,
        S_DONE
    } state_e;

    function automatic addr_t core_en_addr(input int unsigned idx);
        return ADDR_CORE_EN0 + addr_t'(idx);
    endfunction

endpackage

// File: rtl/mmc_launch_master_if.sv
// Launch handshake plus register-bus signals of the launch master.
// master = launch master side, slave = host/responder side.
interface mmc_launch_master_if
    import mmc_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CORE_NUM = 4
);
    logic                launch_valid;
    logic                launch_ready;
    logic [CORE_NUM-1:0] core_mask;
    logic                done_valid;
    logic [1:0]          done_status;
    logic                busy;
    addr_t               address;
    logic                read;
    logic                write;
    logic [WIDTH-1:0]    data_write;
    logic [WIDTH-1:0]    data_read;

    modport master (
        input  launch_valid, core_mask, data_read,
        output launch_ready, done_valid, done_status, busy,
        output address, read, write, data_write
    );

    modport slave (
        output launch_valid, core_mask, data_read,
        input  launch_ready, done_valid, done_status, busy,
        input  address, read, write, data_write
    );
endinterface

// File: rtl/mmc_bus_drv.sv
// Registered bus driver: turns a one-cycle command into a one-cycle
// strobe, keeps read/write exclusive and zeroes address/data when idle.
module mmc_bus_drv
    import mmc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_rd,
    input  logic             cmd_wr,
    input  addr_t            cmd_addr,
    input  logic [WIDTH-1:0] cmd_data,
    output addr_t            address,
    output logic             read,
    output logic             write,
    output logic [WIDTH-1:0] data_write
);
    logic             rd_d, rd_q;
    logic             wr_d, wr_q;
    addr_t            addr_d, addr_q;
    logic [WIDTH-1:0] data_d, data_q;

    // A write command wins over a simultaneous read command.
    always_comb begin
        wr_d   = cmd_wr;
        rd_d   = cmd_rd && !cmd_wr;
        addr_d = (rd_d || wr_d) ? cmd_addr : '0;
        data_d = wr_d ? cmd_data : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign read       = rd_q;
    assign write      = wr_q;
    assign address    = addr_q;
    assign data_write = data_q;

endmodule

// File: rtl/mmc_launch_master.sv
// Launch master: programs core enables, writes START, polls the
// completion latch with a timeout, clears it and reports a status.
module mmc_launch_master
    import mmc_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int CORE_NUM   = 4,
    parameter int START_HOLD = 20,
    parameter int POLL_GAP   = 4,
    parameter int TIMEOUT    = 4096
) (
    input logic                 clk,
    input logic                 reset,
    mmc_launch_master_if.master bus
);
    localparam int IDXW = (CORE_NUM > 1) ? $clog2(CORE_NUM) : 1;
    localparam int TMOW = $clog2(TIMEOUT) + 1;

    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(CORE_NUM - 1);
    localparam logic [7:0]      HOLD_LAST = 8'((START_HOLD > 0) ? START_HOLD - 1 : 0);
    localparam logic [7:0]      GAP_LAST  = 8'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
    localparam logic [TMOW-1:0] TMO_HIT   = TMOW'(TIMEOUT - 1);
    localparam logic [TMOW-1:0] TMO_OVER  = TMOW'(TIMEOUT);
    localparam logic [TMOW-1:0] TMO_MAX   = '1;

    state_e              state_q, state_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [CORE_NUM-1:0] mask_q, mask_d;
    logic [7:0]          hold_cnt_q, hold_cnt_d;
    logic [7:0]          gap_cnt_q, gap_cnt_d;
    logic [TMOW-1:0]     tmo_cnt_q, tmo_cnt_d;
    status_e             status_q, status_d;

    logic                tmo_hit;
    logic                tmo_over;
    logic [TMOW-1:0]     tmo_inc;
    logic                irq_set;

    logic                cmd_rd;
    logic                cmd_wr;
    addr_t               cmd_addr;
    logic [WIDTH-1:0]    cmd_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            mask_q     <= '0;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            status_q   <= ST_OK;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mask_q     <= mask_d;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            status_q   <= status_d;
        end
    end

    // tmo_over means the limit was already reached during the poll read.
    always_comb begin
        tmo_hit  = tmo_cnt_q >= TMO_HIT;
        tmo_over = tmo_cnt_q >= TMO_OVER;
        tmo_inc  = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
        irq_set  = |bus.data_read;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mask_d     = mask_q;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        status_d   = status_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.launch_valid) begin
                    mask_d = bus.core_mask;
                    idx_d  = '0;
                    if (bus.core_mask == '0) begin
                        state_d  = S_DONE;
                        status_d = ST_BAD_MASK;
                    end else begin
                        state_d  = S_WR_EN;
                        status_d = ST_OK;
                    end
                end
            end
            S_WR_EN: begin
                if (idx_q == IDX_LAST) begin
                    state_d = S_WR_START;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_WR_START: begin
                tmo_cnt_d  = '0;
                hold_cnt_d = '0;
                state_d    = S_HOLD;
            end
            S_HOLD: begin
                tmo_cnt_d = tmo_inc;
                if (tmo_hit) begin
                    state_d  = S_CLEAR;
                    status_d = ST_TIMEOUT;
                end else if (hold_cnt_q >= HOLD_LAST) begin
                    state_d = S_POLL_RD;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            S_POLL_RD: begin
                tmo_cnt_d = tmo_inc;
                state_d   = S_POLL_WAIT;
            end
            S_POLL_WAIT: begin
                tmo_cnt_d = tmo_inc;
                if (irq_set) begin
                    state_d  = S_CLEAR;
                    status_d = ST_OK;
                end else if (tmo_over) begin
                    state_d  = S_CLEAR;
                    status_d = ST_TIMEOUT;
                end else if (POLL_GAP == 0) begin
                    state_d = S_POLL_RD;
                end else begin
                    state_d   = S_GAP;
                    gap_cnt_d = '0;
                end
            end
            S_GAP: begin
                tmo_cnt_d = tmo_inc;
                if (tmo_hit) begin
                    state_d  = S_CLEAR;
                    status_d = ST_TIMEOUT;
                end else if (gap_cnt_q >= GAP_LAST) begin
                    state_d = S_POLL_RD;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            S_CLEAR: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Commands follow the next state so the registered strobe lines up
    // with the state that owns it.
    always_comb begin
        cmd_rd   = 1'b0;
        cmd_wr   = 1'b0;
        cmd_addr = '0;
        cmd_data = '0;
        case (state_d)
            S_WR_EN: begin
                cmd_wr   = 1'b1;
                cmd_addr = core_en_addr(32'(idx_d));
                cmd_data = WIDTH'(mask_d[idx_d]);
            end
            S_WR_START: begin
                cmd_wr   = 1'b1;
                cmd_addr = ADDR_START;
                cmd_data = WIDTH'(1);
            end
            S_POLL_RD: begin
                cmd_rd   = 1'b1;
                cmd_addr = ADDR_IRQ;
            end
            S_CLEAR: begin
                cmd_wr   = 1'b1;
                cmd_addr = ADDR_IRQ;
            end
            default: ;
        endcase
        bus.launch_ready = state_q == S_IDLE;
        bus.busy         = state_q != S_IDLE;
        bus.done_valid   = state_q == S_DONE;
        bus.done_status  = status_q;
    end

    mmc_bus_drv #(
        .WIDTH(WIDTH)
    ) u_bus_drv (
        .clk       (clk),
        .reset     (reset),
        .cmd_rd    (cmd_rd),
        .cmd_wr    (cmd_wr),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .address   (bus.address),
        .read      (bus.read),
        .write     (bus.write),
        .data_write(bus.data_write)
    );

endmodule

// File: tb/tb_mmc_launch_master.sv
// Directed bench for mmc_launch_master with a register-map responder
// whose completion interrupt is driven from the stimulus tasks.
module tb_mmc_launch_master;
    import mmc_pkg::*;

    typedef struct {
        int c;
        int a;
        int d;
    } acc_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic irq   = 1'b0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0       = 0;

    acc_t wq[$];
    int   rdq[$];
    int   dq[$];
    int   nreads  = 0;
    int   nstarts = 0;
    int   bus_bad = 0;
    logic rd_d1   = 1'b0;

    logic       irq_latch = 1'b0;
    logic       start_o   = 1'b0;
    int         since     = 100;
    logic [3:0] core_en   = 4'd0;

    mmc_launch_master_if #(.WIDTH(8), .CORE_NUM(4)) bus ();

    mmc_launch_master #(
        .WIDTH     (8),
        .CORE_NUM  (4),
        .START_HOLD(20),
        .POLL_GAP  (4),
        .TIMEOUT   (64)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Responder: core enables, START (ignored for 20 cycles after a start),
    // and the completion latch set by irq, cleared by a write to it.
    always @(posedge clk) begin
        start_o <= 1'b0;
        if (since < 100) since <= since + 1;
        if (bus.write) begin
            case (bus.address)
                3'd0: begin
                    if (bus.data_write[0] && since >= 20) begin
                        start_o <= 1'b1;
                        since   <= 0;
                    end
                end
                3'd1: irq_latch <= 1'b0;
                default: begin
                    if (bus.address <= 3'd5)
                        core_en[bus.address[1:0] - 2'd2] <= bus.data_write[0];
                end
            endcase
        end
        if (irq) irq_latch <= 1'b1;
        if (bus.read)
            bus.data_read <= (bus.address == 3'd1) ? {7'd0, irq_latch} : 8'd0;
    end

    always @(negedge clk) begin
        if (bus.write) wq.push_back('{cyc, int'(bus.address), int'(bus.data_write)});
        if (bus.read) nreads <= nreads + 1;
        if (rd_d1) rdq.push_back(int'(bus.data_read));
        rd_d1 <= bus.read;
        if (bus.done_valid) dq.push_back(cyc);
        if (start_o) nstarts <= nstarts + 1;
        if ((bus.read && bus.write) ||
            (!bus.read && !bus.write && (bus.address != 3'd0 || bus.data_write != 8'd0)))
            bus_bad <= bus_bad + 1;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_logs();
        @(posedge clk);
        #1;
        wq.delete();
        rdq.delete();
        dq.delete();
        nreads  = 0;
        nstarts = 0;
        step();
    endtask

    task automatic launch(input logic [3:0] m);
        bus.core_mask    = m;
        bus.launch_valid = 1'b1;
        t0               = cyc;
        step();
        bus.launch_valid = 1'b0;
    endtask

    task automatic pulse_irq();
        irq = 1'b1;
        step();
        irq = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int rel);
        rel = -1;
        for (int i = 0; i < budget; i++) begin
            if (dq.size() != 0) break;
            step();
        end
        if (dq.size() != 0) rel = dq[0] - t0;
    endtask

    function automatic int start_rel(input int n);
        int k = 0;
        foreach (wq[i]) begin
            if (wq[i].a == 0) begin
                if (k == n) return wq[i].c - t0;
                k++;
            end
        end
        return -1;
    endfunction

    function automatic int count_starts();
        int k = 0;
        foreach (wq[i]) if (wq[i].a == 0) k++;
        return k;
    endfunction

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        checks++; if (bus.address !== 3'd0) begin failures++; $display("FAIL rst_addr got=%0d exp=0", bus.address); end
        checks++; if (bus.read !== 1'b0) begin failures++; $display("FAIL rst_read got=%0b exp=0", bus.read); end
        checks++; if (bus.write !== 1'b0) begin failures++; $display("FAIL rst_write got=%0b exp=0", bus.write); end
        checks++; if (bus.data_write !== 8'd0) begin failures++; $display("FAIL rst_wdata got=%0d exp=0", bus.data_write); end
        checks++; if (bus.done_valid !== 1'b0) begin failures++; $display("FAIL rst_done got=%0b exp=0", bus.done_valid); end
        checks++; if (bus.done_status !== 2'b00) begin failures++; $display("FAIL rst_status got=%0b exp=00", bus.done_status); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", bus.busy); end
        checks++; if (bus.launch_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0b exp=1", bus.launch_ready); end
        repeat (3) step();
        reset = 1'b0;
        repeat (2) step();
        checks++; if (bus.launch_ready !== 1'b1) begin failures++; $display("FAIL idle_ready got=%0b exp=1", bus.launch_ready); end
    endtask

    task automatic test_bad_mask();
        clr_logs();
        launch(4'b0000);
        checks++; if (bus.done_valid !== 1'b1) begin failures++; $display("FAIL bad_done got=%0b exp=1", bus.done_valid); end
        checks++; if (bus.done_status !== 2'b10) begin failures++; $display("FAIL bad_status got=%0b exp=10", bus.done_status); end
        step();
        checks++; if (bus.done_valid !== 1'b0) begin failures++; $display("FAIL bad_pulse got=%0b exp=0", bus.done_valid); end
        repeat (3) step();
        checks++; if (wq.size() != 0) begin failures++; $display("FAIL bad_writes got=%0d exp=0", wq.size()); end
        checks++; if (nreads != 0) begin failures++; $display("FAIL bad_reads got=%0d exp=0", nreads); end
        checks++; if (dq.size() != 1) begin failures++; $display("FAIL bad_ndone got=%0d exp=1", dq.size()); end
    endtask

    task automatic test_basic();
        int ea[6] = '{2, 3, 4, 5, 0, 1};
        int ed[6] = '{1, 1, 0, 1, 1, 0};
        int ec[6] = '{1, 2, 3, 4, 5, 28};
        int rel;
        clr_logs();
        launch(4'b1011);
        repeat (9) step();
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%0b exp=1", bus.busy); end
        checks++; if (bus.launch_ready !== 1'b0) begin failures++; $display("FAIL basic_ready got=%0b exp=0", bus.launch_ready); end
        pulse_irq();
        wait_done(60, rel);
        checks++; if (rel != 29) begin failures++; $display("FAIL basic_latency got=%0d exp=29", rel); end
        checks++; if (bus.done_status !== 2'b00) begin failures++; $display("FAIL basic_status got=%0b exp=00", bus.done_status); end
        checks++; if (wq.size() != 6) begin failures++; $display("FAIL basic_nwr got=%0d exp=6", wq.size()); end
        if (wq.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (wq[i].a != ea[i] || wq[i].d != ed[i] || wq[i].c - t0 != ec[i]) begin
                    failures++;
                    $display("FAIL basic_wr%0d got=(%0d,%0d)@%0d exp=(%0d,%0d)@%0d",
                             i, wq[i].a, wq[i].d, wq[i].c - t0, ea[i], ed[i], ec[i]);
                end
            end
        end
        checks++; if (nreads != 1) begin failures++; $display("FAIL basic_nrd got=%0d exp=1", nreads); end
        checks++; if (rdq.size() != 1 || rdq[0] != 1) begin failures++; $display("FAIL basic_rdata got=%0d exp=1", rdq.size() != 0 ? rdq[0] : -1); end
        checks++; if (core_en !== 4'b1011) begin failures++; $display("FAIL basic_core_en got=%b exp=1011", core_en); end
        checks++; if (nstarts != 1) begin failures++; $display("FAIL basic_starts got=%0d exp=1", nstarts); end
        step();
        checks++; if (bus.done_valid !== 1'b0) begin failures++; $display("FAIL basic_pulse got=%0b exp=0", bus.done_valid); end
        checks++; if (bus.done_status !== 2'b00) begin failures++; $display("FAIL basic_hold got=%0b exp=00", bus.done_status); end
        step();
    endtask

    task automatic test_timeout();
        int rel;
        int nz = 0;
        clr_logs();
        launch(4'b0110);
        wait_done(120, rel);
        checks++; if (rel != 72) begin failures++; $display("FAIL tmo_latency got=%0d exp=72", rel); end
        checks++; if (bus.done_status !== 2'b01) begin failures++; $display("FAIL tmo_status got=%0b exp=01", bus.done_status); end
        checks++; if (start_rel(0) != 5) begin failures++; $display("FAIL tmo_start got=%0d exp=5", start_rel(0)); end
        checks++; if (nreads != 8) begin failures++; $display("FAIL tmo_nrd got=%0d exp=8", nreads); end
        foreach (rdq[i]) if (rdq[i] != 0) nz++;
        checks++; if (nz != 0) begin failures++; $display("FAIL tmo_rdata got=%0d exp=0", nz); end
        checks++; if (wq.size() != 6) begin failures++; $display("FAIL tmo_nwr got=%0d exp=6", wq.size()); end
        if (wq.size() == 6) begin
            checks++;
            if (wq[5].a != 1 || wq[5].d != 0 || wq[5].c - t0 != 71) begin
                failures++;
                $display("FAIL tmo_clear got=(%0d,%0d)@%0d exp=(1,0)@71", wq[5].a, wq[5].d, wq[5].c - t0);
            end
        end
        repeat (2) step();
    endtask

    task automatic test_late_irq();
        int rel;
        int nz = 0;
        clr_logs();
        launch(4'b0001);
        for (int i = 0; i < 20; i++) begin
            if (start_rel(0) >= 0) break;
            step();
        end
        checks++; if (start_rel(0) != 5) begin failures++; $display("FAIL late_start got=%0d exp=5", start_rel(0)); end
        repeat (40) step();
        pulse_irq();
        wait_done(100, rel);
        checks++; if (rel != 53) begin failures++; $display("FAIL late_latency got=%0d exp=53", rel); end
        checks++; if (bus.done_status !== 2'b00) begin failures++; $display("FAIL late_status got=%0b exp=00", bus.done_status); end
        checks++; if (nreads != 5) begin failures++; $display("FAIL late_nrd got=%0d exp=5", nreads); end
        foreach (rdq[i]) if (rdq[i] == 0) nz++;
        checks++; if (nz != 4) begin failures++; $display("FAIL late_zero_polls got=%0d exp=4", nz); end
        repeat (2) step();
    endtask

    task automatic test_reset_mid();
        int rel;
        clr_logs();
        launch(4'b1111);
        for (int i = 0; i < 40; i++) begin
            if (nreads != 0) break;
            step();
        end
        step();
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.read !== 1'b0 || bus.write !== 1'b0) begin failures++; $display("FAIL mid_strobes got=%0b%0b exp=00", bus.read, bus.write); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%0b exp=0", bus.busy); end
        checks++; if (bus.launch_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%0b exp=1", bus.launch_ready); end
        repeat (2) step();
        reset = 1'b0;
        clr_logs();
        repeat (10) step();
        checks++; if (dq.size() != 0) begin failures++; $display("FAIL mid_no_done got=%0d exp=0", dq.size()); end
        checks++; if (wq.size() != 0 || nreads != 0) begin failures++; $display("FAIL mid_no_bus got=%0d exp=0", wq.size() + nreads); end
        launch(4'b0100);
        repeat (9) step();
        pulse_irq();
        wait_done(60, rel);
        checks++; if (rel != 29) begin failures++; $display("FAIL mid_relaunch got=%0d exp=29", rel); end
        checks++; if (bus.done_status !== 2'b00) begin failures++; $display("FAIL mid_status got=%0b exp=00", bus.done_status); end
        checks++;
        if (wq.size() != 6 || wq[0].d != 0 || wq[2].a != 4 || wq[2].d != 1) begin
            failures++;
            $display("FAIL mid_en_writes got=%0d exp=6", wq.size());
        end
        repeat (2) step();
    endtask

    task automatic test_back_to_back();
        int nst = 0;
        int s0;
        int s1;
        pulse_irq();
        clr_logs();
        bus.core_mask    = 4'b1011;
        bus.launch_valid = 1'b1;
        t0               = cyc;
        for (int i = 0; i < 120; i++) begin
            if (dq.size() >= 2) break;
            step();
            irq = 1'b0;
            if (count_starts() > nst) begin
                nst++;
                irq = 1'b1;
            end
        end
        bus.launch_valid = 1'b0;
        irq              = 1'b0;
        repeat (4) step();
        checks++; if (dq.size() != 2) begin failures++; $display("FAIL b2b_ndone got=%0d exp=2", dq.size()); end
        if (dq.size() == 2) begin
            checks++; if (dq[0] - t0 != 29) begin failures++; $display("FAIL b2b_done0 got=%0d exp=29", dq[0] - t0); end
            checks++; if (dq[1] - t0 != 59) begin failures++; $display("FAIL b2b_done1 got=%0d exp=59", dq[1] - t0); end
        end
        s0 = start_rel(0);
        s1 = start_rel(1);
        checks++; if (s0 != 5 || s1 != 35) begin failures++; $display("FAIL b2b_starts got=%0d,%0d exp=5,35", s0, s1); end
        checks++; if (s1 - s0 < 20) begin failures++; $display("FAIL b2b_spacing got=%0d exp>=20", s1 - s0); end
        checks++; if (nstarts != 2) begin failures++; $display("FAIL b2b_start_pulses got=%0d exp=2", nstarts); end
        checks++; if (count_starts() != 2) begin failures++; $display("FAIL b2b_no_third got=%0d exp=2", count_starts()); end
        checks++; if (bus.launch_ready !== 1'b1) begin failures++; $display("FAIL b2b_idle got=%0b exp=1", bus.launch_ready); end
    endtask

    task automatic test_bus_rules();
        checks++; if (bus_bad != 0) begin failures++; $display("FAIL bus_rules got=%0d exp=0", bus_bad); end
    endtask

    initial begin
        bus.launch_valid = 1'b0;
        bus.core_mask    = 4'd0;
        test_reset();
        test_bad_mask();
        test_basic();
        test_timeout();
        test_late_irq();
        test_reset_mid();
        test_back_to_back();
        test_bus_rules();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
